// File: rtl/clock_ratio_monitor.sv
// rtl/clock_ratio_monitor.sv - period/high-time monitor with lock, ratio and stall detection
module clock_ratio_monitor #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 4,
  parameter int TIMEOUT     = 1000
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             sig_in,
  input  logic [CNT_W-1:0] exp_div,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             ratio_ok,
  output logic             stalled
);

  localparam logic [CNT_W-1:0] TMO   = CNT_W'(TIMEOUT);
  localparam logic [3:0]       LOCKN = 4'(LOCK_COUNT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s_d;
  logic [CNT_W-1:0]       r_cnt_run;
  logic [CNT_W-1:0]       r_high_run;
  logic [CNT_W-1:0]       r_period;
  logic [CNT_W-1:0]       r_high_time;
  logic [3:0]             r_match_cnt;
  logic                   r_first;
  logic                   r_meas_valid;
  logic                   r_locked;
  logic                   r_ratio_ok;
  logic                   r_stalled;
  state_t                 r_state;

  logic                   w_s;
  logic                   w_rise;
  logic                   w_same;
  logic [3:0]             w_inc;
  state_t                 w_state_nxt;
  logic [3:0]             w_match_nxt;
  logic                   w_locked_nxt;
  logic                   w_stalled_nxt;
  logic                   w_first_nxt;
  logic                   w_load;

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_rise = w_s & ~r_s_d;
  // A new measurement equals the one currently on the outputs
  assign w_same = (r_cnt_run == r_period) && (r_high_run == r_high_time);
  assign w_inc  = (r_match_cnt == 4'hF) ? 4'hF : r_match_cnt + 4'd1;

  // Sampling chain and delayed copy for rise detection
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_sync <= '0;
      r_s_d  <= 1'b0;
    end else begin
      r_sync[0] <= sig_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_s_d <= w_s;
    end
  end

  // Run counters: restart at 1 on every rise, saturate at TIMEOUT otherwise
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_cnt_run  <= '0;
      r_high_run <= '0;
    end else if (w_rise) begin
      r_cnt_run  <= CNT_W'(1);
      r_high_run <= CNT_W'(1);
    end else begin
      if (r_cnt_run != TMO) begin
        r_cnt_run <= r_cnt_run + CNT_W'(1);
      end
      if (w_s && (r_high_run != TMO)) begin
        r_high_run <= r_high_run + CNT_W'(1);
      end
    end
  end

  // FSM state and status register update
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state      <= IDLE;
      r_match_cnt  <= '0;
      r_first      <= 1'b0;
      r_locked     <= 1'b0;
      r_stalled    <= 1'b0;
      r_meas_valid <= 1'b0;
      r_period     <= '0;
      r_high_time  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_match_cnt  <= w_match_nxt;
      r_first      <= w_first_nxt;
      r_locked     <= w_locked_nxt;
      r_stalled    <= w_stalled_nxt;
      r_meas_valid <= w_load;
      if (w_load) begin
        r_period    <= r_cnt_run;
        r_high_time <= r_high_run;
      end
    end
  end

  // Next-state logic: a rise always wins over the timeout
  always_comb begin
    w_state_nxt   = r_state;
    w_match_nxt   = r_match_cnt;
    w_locked_nxt  = r_locked;
    w_stalled_nxt = r_stalled;
    w_first_nxt   = r_first;
    w_load        = 1'b0;
    if (w_rise) begin
      w_stalled_nxt = 1'b0;
      unique case (r_state)
        IDLE: begin
          w_state_nxt  = MEASURE;
          w_first_nxt  = 1'b1;
          w_match_nxt  = 4'd0;
          w_locked_nxt = 1'b0;
        end
        MEASURE: begin
          w_load      = 1'b1;
          w_first_nxt = 1'b0;
          if (r_first) begin
            w_match_nxt = 4'd1;
          end else if (w_same) begin
            w_match_nxt = w_inc;
          end else begin
            w_match_nxt = 4'd0;
          end
          if (w_match_nxt >= LOCKN) begin
            w_state_nxt  = LOCKED;
            w_locked_nxt = 1'b1;
          end
        end
        LOCKED: begin
          w_load = 1'b1;
          if (w_same) begin
            w_match_nxt = w_inc;
          end else begin
            w_match_nxt  = 4'd1;
            w_locked_nxt = 1'b0;
            w_state_nxt  = MEASURE;
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end else if (r_cnt_run == TMO) begin
      w_stalled_nxt = 1'b1;
      w_locked_nxt  = 1'b0;
      w_match_nxt   = 4'd0;
      w_first_nxt   = 1'b0;
      w_state_nxt   = IDLE;
    end
  end

  // Ratio check is registered so it follows locked/period/exp_div by one cycle
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_ratio_ok <= 1'b0;
    end else begin
      r_ratio_ok <= r_locked && (r_period == exp_div);
    end
  end

  assign period     = r_period;
  assign high_time  = r_high_time;
  assign meas_valid = r_meas_valid;
  assign locked     = r_locked;
  assign ratio_ok   = r_ratio_ok;
  assign stalled    = r_stalled;

endmodule
